uart_cmd_slave: RTL and testbench

//  DSO-side end of the host command link; the host side is the UART master.

---
 rtl/uart_cmd_slave.sv | 210 +++++++++++++++++++++
 tb/tb_uart_cmd_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_cmd_slave
// Brief   : Host-link UART; assembles 3-byte commands, sends 1-byte responses.
// Revision: 1.0
// ============================================================================
module uart_cmd_slave #(
  parameter int BAUD_DIV = 2604,
  parameter int GAP_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int              c_GAP_CYC   = GAP_BITS * BAUD_DIV;
  localparam int              c_GAP_W     = $clog2(c_GAP_CYC + 1);
  localparam logic [11:0]     c_BAUD_FULL = 12'(BAUD_DIV - 1);
  localparam logic [11:0]     c_BAUD_HALF = 12'(BAUD_DIV / 2);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_CYC - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  logic               r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]         r_rx_state;
  logic [11:0]        r_rx_baud;
  logic [2:0]         r_rx_bit;
  logic [7:0]         r_rx_shift;
  logic [1:0]         r_byte_cnt;
  logic [23:8]        r_cmd_hold;
  logic [c_GAP_W-1:0] r_gap_cnt;

  logic [1:0]         r_tx_state;
  logic [11:0]        r_tx_baud;
  logic [2:0]         r_tx_bit;
  logic [7:0]         r_tx_shift;

  logic w_rx_fall, w_start_det, w_stop_tick, w_byte_ok, w_cmd_set, w_cmd_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= RX;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_rx_fall   = r_rx_prev & ~r_rx_s2;
  assign w_start_det = (r_rx_state == c_ST_IDLE) && w_rx_fall;
  assign w_stop_tick = (r_rx_state == c_ST_STOP) && (r_rx_baud == 12'd0);
  assign w_byte_ok   = w_stop_tick && r_rx_s2;
  assign w_cmd_set   = w_byte_ok && (r_byte_cnt == 2'd2);
  assign w_cmd_clr   = clr_cmd_rdy || (w_start_det && (r_byte_cnt == 2'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= c_ST_IDLE;
      r_rx_baud  <= 12'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
      r_byte_cnt <= 2'd0;
      r_cmd_hold <= 16'd0;
      r_gap_cnt  <= '0;
      cmd        <= 24'd0;
      frm_err    <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      case (r_rx_state)
        c_ST_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= c_ST_START;
            r_rx_baud  <= c_BAUD_HALF;
            r_gap_cnt  <= '0;
          end else if (r_byte_cnt != 2'd0) begin
            // Partial command abandoned by the host: drop it.
            if (r_gap_cnt == c_GAP_LAST) begin
              r_byte_cnt <= 2'd0;
              r_gap_cnt  <= '0;
              frm_err    <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
        end
        c_ST_START: begin
          if (r_rx_baud != 12'd0) begin
            r_rx_baud <= r_rx_baud - 12'd1;
          end else if (r_rx_s2) begin
            r_rx_state <= c_ST_IDLE;
          end else begin
            r_rx_state <= c_ST_DATA;
            r_rx_baud  <= c_BAUD_FULL;
            r_rx_bit   <= 3'd0;
          end
        end
        c_ST_DATA: begin
          if (r_rx_baud != 12'd0) begin
            r_rx_baud <= r_rx_baud - 12'd1;
          end else begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_baud  <= c_BAUD_FULL;
            if (r_rx_bit == 3'd7) r_rx_state <= c_ST_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end
        end
        default: begin
          if (r_rx_baud != 12'd0) begin
            r_rx_baud <= r_rx_baud - 12'd1;
          end else begin
            r_rx_state <= c_ST_IDLE;
            if (!r_rx_s2) begin
              frm_err    <= 1'b1;
              r_byte_cnt <= 2'd0;
            end else begin
              case (r_byte_cnt)
                2'd0:    begin r_cmd_hold[23:16] <= r_rx_shift; r_byte_cnt <= 2'd1; end
                2'd1:    begin r_cmd_hold[15:8]  <= r_rx_shift; r_byte_cnt <= 2'd2; end
                default: begin cmd <= {r_cmd_hold[23:8], r_rx_shift}; r_byte_cnt <= 2'd0; end
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         cmd_rdy <= 1'b0;
    else if (w_cmd_set) cmd_rdy <= 1'b1;
    else if (w_cmd_clr) cmd_rdy <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= c_ST_IDLE;
      r_tx_baud  <= 12'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      TX         <= 1'b1;
      tx_busy    <= 1'b0;
      resp_sent  <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (r_tx_state)
        c_ST_IDLE: begin
          if (send_resp) begin
            r_tx_shift <= resp;
            r_tx_baud  <= c_BAUD_FULL;
            r_tx_state <= c_ST_START;
            tx_busy    <= 1'b1;
            TX         <= 1'b0;
          end
        end
        c_ST_START: begin
          if (r_tx_baud != 12'd0) begin
            r_tx_baud <= r_tx_baud - 12'd1;
          end else begin
            r_tx_state <= c_ST_DATA;
            r_tx_baud  <= c_BAUD_FULL;
            r_tx_bit   <= 3'd0;
            TX         <= r_tx_shift[0];
          end
        end
        c_ST_DATA: begin
          if (r_tx_baud != 12'd0) begin
            r_tx_baud <= r_tx_baud - 12'd1;
          end else begin
            r_tx_baud  <= c_BAUD_FULL;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= c_ST_STOP;
              TX         <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              TX       <= r_tx_shift[1];
            end
          end
        end
        default: begin
          if (r_tx_baud != 12'd0) begin
            r_tx_baud <= r_tx_baud - 12'd1;
          end else begin
            r_tx_state <= c_ST_IDLE;
            tx_busy    <= 1'b0;
            resp_sent  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_cmd_slave
// Brief   : Directed bench with a host UART model driving RX and sampling TX.
// Revision: 1.0
// ============================================================================
module tb_uart_cmd_slave;
  localparam int c_BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_busy, resp_sent, frm_err;
  logic [23:0] cmd;

  int n_cmp = 0;
  int n_bad = 0;
  int frm_cnt = 0;

  uart_cmd_slave #(.BAUD_DIV(c_BD), .GAP_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .tx_busy(tx_busy), .resp_sent(resp_sent), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frm_err === 1'b1) frm_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b);
    RX = b;
    tick(c_BD);
  endtask

  // Full frame followed by one idle bit-time.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit(stop_bit);
    RX = 1'b1;
    tick(c_BD);
  endtask

  logic [7:0] host_got;
  int t_err;
  int f0;

  initial begin
    tick(3);
    check("rst_TX", TX, 1);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_resp_sent", resp_sent, 0);
    check("rst_frm_err", frm_err, 0);
    rst_n = 1'b1;
    tick(5);

    // 1: first command
    send_byte(8'h02, 1'b1);
    send_byte(8'h0C, 1'b1);
    check("t1_cmd_before", cmd, 0);
    check("t1_rdy_before", cmd_rdy, 0);
    send_byte(8'h00, 1'b1);
    check("t1_cmd", cmd, 24'h020C00);
    check("t1_rdy", cmd_rdy, 1);

    // 2: new command while cmd_rdy held
    check("t2_rdy_held", cmd_rdy, 1);
    RX = 1'b0;
    tick(10);
    check("t2_rdy_drop_at_start", cmd_rdy, 0);
    tick(c_BD - 10);
    for (int i = 0; i < 8; i++) put_bit(1'(8'h03 >> i));
    put_bit(1'b1);
    tick(c_BD);
    send_byte(8'h0C, 1'b1);
    check("t2_cmd_atomic", cmd, 24'h020C00);
    send_byte(8'h81, 1'b1);
    check("t2_cmd", cmd, 24'h030C81);
    check("t2_rdy", cmd_rdy, 1);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check("t2_clr", cmd_rdy, 0);

    // 3: response transmit with an ignored second strobe
    resp = 8'hA5;
    send_resp = 1'b1;
    check("t3_TX_idle_on_strobe", TX, 1);
    fork
      begin : host_rx
        int w;
        w = 0;
        host_got = 8'h00;
        while (TX !== 1'b0 && w < 40) begin tick(1); w++; end
        check("t3_host_start_seen", TX, 0);
        tick(c_BD / 2);
        check("t3_host_start_mid", TX, 0);
        for (int i = 0; i < 8; i++) begin
          tick(c_BD);
          host_got[i] = TX;
        end
        tick(c_BD);
        check("t3_host_stop", TX, 1);
      end
      begin : drv
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        tick(1);
        send_resp = 1'b0;
        check("t3_TX_low", TX, 0);
        check("t3_busy", tx_busy, 1);
        while (!seen && n < 200) begin
          tick(1);
          n++;
          if (n == 49) begin resp = 8'h5A; send_resp = 1'b1; end
          else if (n == 50) send_resp = 1'b0;
          if (resp_sent === 1'b1) seen = 1'b1;
        end
        check("t3_resp_sent_cycles", n, 160);
        check("t3_busy_cleared", tx_busy, 0);
      end
    join
    check("t3_host_byte", host_got, 8'hA5);
    tick(5);
    check("t3_second_ignored_busy", tx_busy, 0);
    check("t3_second_ignored_TX", TX, 1);

    // 4: inter-byte gap timeout
    f0 = frm_cnt;
    send_byte(8'h07, 1'b1);
    t_err = -1;
    for (int i = 1; i <= 24 * c_BD; i++) begin
      tick(1);
      if (frm_err === 1'b1 && t_err < 0) t_err = i;
    end
    check("t4_gap_pulses", frm_cnt - f0, 1);
    check("t4_gap_time_window", (t_err >= 280 && t_err <= 320), 1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t4_cmd", cmd, 24'h090600);
    check("t4_rdy", cmd_rdy, 1);
    check("t4_no_extra_err", frm_cnt - f0, 1);

    // 5: bad stop bit, then a glitch
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    f0 = frm_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'hAB, 1'b0);
    check("t5_stop_err", frm_cnt - f0, 1);
    check("t5_rdy_after_err", cmd_rdy, 0);
    RX = 1'b0;
    tick(1);
    RX = 1'b1;
    tick(3 * c_BD);
    check("t5_glitch_no_err", frm_cnt - f0, 1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("t5_rdy_partial", cmd_rdy, 0);
    check("t5_cmd_unchanged", cmd, 24'h090600);
    send_byte(8'h44, 1'b1);
    check("t5_cmd_resync", cmd, 24'h223344);
    check("t5_rdy_resync", cmd_rdy, 1);

    // 6: reset mid TX frame and mid RX byte
    resp = 8'h3C;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    tick(30);
    RX = 1'b0;
    tick(40);
    check("t6_busy_before", tx_busy, 1);
    rst_n = 1'b0;
    RX = 1'b1;
    tick(1);
    check("t6_TX", TX, 1);
    check("t6_busy", tx_busy, 0);
    check("t6_rdy", cmd_rdy, 0);
    check("t6_cmd", cmd, 0);
    rst_n = 1'b1;
    tick(20);
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h04, 1'b1);
    check("t6_cmd_after", cmd, 24'h050104);
    check("t6_rdy_after", cmd_rdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
